// File: rtl/interrupt_dispatcher_pkg.sv
// Shared types for the interrupt dispatcher: FSM state encoding and encode widths.
package interrupt_dispatcher_pkg;

  localparam int SVC_WIDTH = 32;
  localparam int ID_WIDTH  = $clog2(SVC_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DISPATCH,
    SERVICE,
    CLEAR,
    HOLDOFF
  } disp_state_t;

endpackage

// File: rtl/irq_onehot_encode.sv
// Combinational 32->5 encoder; valid only when exactly one bit is set.
module irq_onehot_encode
  import interrupt_dispatcher_pkg::*;
(
  input  logic [SVC_WIDTH-1:0] word,
  output logic [ID_WIDTH-1:0]  index,
  output logic                 valid,
  output logic                 zero
);

  logic [ID_WIDTH:0] ones;

  // OR-ing indices is exact for one-hot words; other words are flagged invalid anyway
  always_comb begin
    ones  = '0;
    index = '0;
    for (int i = 0; i < SVC_WIDTH; i++) begin
      if (word[i]) begin
        ones  = ones + 1'b1;
        index = index | ID_WIDTH'(i);
      end
    end
  end

  assign valid = (ones == (ID_WIDTH + 1)'(1));
  assign zero  = (word == '0);

endmodule

// File: rtl/interrupt_dispatcher.sv
// Processor-side responder: captures the controller's service word, dispatches it
// to the handler over req/ack, waits for done (with timeout) and pulses the clear.
module interrupt_dispatcher
  import interrupt_dispatcher_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 proc_interrupt,
  input  logic [SVC_WIDTH-1:0] interrupt_serviceInterrupt,
  output logic                 interrupt_clear,
  input  logic                 dispatch_en,
  output logic                 irq_req,
  output logic [ID_WIDTH-1:0]  irq_id,
  input  logic                 irq_ack,
  input  logic                 irq_done,
  output logic                 busy,
  output logic                 timeout_flag,
  input  logic                 timeout_clr,
  output logic [CNT_WIDTH-1:0] serviced_cnt,
  output logic [7:0]           spurious_cnt
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HCNT_W = $clog2(HOLDOFF_CYCLES + 1);

  disp_state_t         state;
  logic                proc_interrupt_d;
  logic                pending;
  logic                rise;
  logic [TCNT_W-1:0]   tmo_cnt;
  logic [HCNT_W-1:0]   hold_cnt;
  logic [ID_WIDTH-1:0] svc_index;
  logic                svc_valid;
  logic                svc_zero;
  logic                spurious;
  logic                timeout_hit;
  logic                hold_done;

  // The word is encoded straight off the input while in CAPTURE; only the id is kept
  irq_onehot_encode u_encode (
    .word  (interrupt_serviceInterrupt),
    .index (svc_index),
    .valid (svc_valid),
    .zero  (svc_zero)
  );

  assign rise        = proc_interrupt & ~proc_interrupt_d;
  assign spurious    = svc_zero | ~svc_valid;
  assign timeout_hit = (tmo_cnt == TCNT_W'(TIMEOUT_CYCLES - 1));
  assign hold_done   = (hold_cnt == HCNT_W'(HOLDOFF_CYCLES - 1));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      proc_interrupt_d <= 1'b0;
      pending          <= 1'b0;
      irq_req          <= 1'b0;
      irq_id           <= '0;
      interrupt_clear  <= 1'b0;
      timeout_flag     <= 1'b0;
      serviced_cnt     <= '0;
      spurious_cnt     <= '0;
      tmo_cnt          <= '0;
      hold_cnt         <= '0;
    end else begin
      proc_interrupt_d <= proc_interrupt;
      interrupt_clear  <= 1'b0;
      if (rise) pending <= 1'b1;
      if (timeout_clr) timeout_flag <= 1'b0;

      case (state)
        IDLE: begin
          // A rise landing on the launch cycle keeps pending set for a later service
          if (pending && dispatch_en) begin
            pending <= rise;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (spurious) begin
            if (spurious_cnt != 8'hFF) spurious_cnt <= spurious_cnt + 1'b1;
            interrupt_clear <= 1'b1;
            state           <= CLEAR;
          end else begin
            irq_id  <= svc_index;
            irq_req <= 1'b1;
            state   <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (irq_ack) begin
            irq_req <= 1'b0;
            tmo_cnt <= '0;
            state   <= SERVICE;
          end
        end
        SERVICE: begin
          // done wins over a same-cycle timeout
          if (irq_done) begin
            if (serviced_cnt != '1) serviced_cnt <= serviced_cnt + 1'b1;
            interrupt_clear <= 1'b1;
            state           <= CLEAR;
          end else if (timeout_hit) begin
            if (!timeout_clr) timeout_flag <= 1'b1;
            interrupt_clear <= 1'b1;
            state           <= CLEAR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CLEAR: begin
          hold_cnt <= '0;
          state    <= HOLDOFF;
        end
        HOLDOFF: begin
          if (hold_done) state <= IDLE;
          else           hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Randomized bench for interrupt_dispatcher against a transaction-level reference model.
module tb_interrupt_dispatcher;

  localparam int TIMEOUT_CYCLES = 8;
  localparam int HOLDOFF_CYCLES = 4;
  localparam int CNT_WIDTH      = 4;
  localparam int SERVICED_MAX   = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 proc_interrupt = 1'b0;
  logic [31:0]          interrupt_serviceInterrupt = '0;
  logic                 dispatch_en = 1'b0;
  logic                 irq_ack = 1'b0;
  logic                 irq_done = 1'b0;
  logic                 timeout_clr = 1'b0;
  logic                 interrupt_clear;
  logic                 irq_req;
  logic [4:0]           irq_id;
  logic                 busy;
  logic                 timeout_flag;
  logic [CNT_WIDTH-1:0] serviced_cnt;
  logic [7:0]           spurious_cnt;

  int   test_count = 0;
  int   fail_count = 0;
  int   clear_count = 0;
  int   req_rises = 0;
  int   pulse_left = 0;
  logic clear_prev = 1'b0;
  logic req_prev = 1'b0;

  // reference model state
  int   exp_serviced = 0;
  int   exp_spurious = 0;
  logic exp_flag = 1'b0;

  interrupt_dispatcher #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .proc_interrupt             (proc_interrupt),
    .interrupt_serviceInterrupt (interrupt_serviceInterrupt),
    .interrupt_clear            (interrupt_clear),
    .dispatch_en                (dispatch_en),
    .irq_req                    (irq_req),
    .irq_id                     (irq_id),
    .irq_ack                    (irq_ack),
    .irq_done                   (irq_done),
    .busy                       (busy),
    .timeout_flag               (timeout_flag),
    .timeout_clr                (timeout_clr),
    .serviced_cnt               (serviced_cnt),
    .spurious_cnt               (spurious_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulse counters and single-cycle clear width, sampled mid-cycle
  always @(negedge clk) begin
    if (clear_prev) checkOutput("clear_width", 32'(interrupt_clear), 32'd0);
    if (interrupt_clear) clear_count++;
    if (irq_req && !req_prev) req_rises++;
    clear_prev = interrupt_clear;
    req_prev   = irq_req;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int ref_index(input logic [31:0] w);
    if ($countones(w) != 1) return -1;
    return $clog2(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (pulse_left > 0) begin
      pulse_left--;
      if (pulse_left == 0) proc_interrupt = 1'b0;
    end
  endtask

  // Runs from the cycle CAPTURE is visible up to the cycle the clear is visible
  task automatic serviceTxn(input int idx, input int ack_dly, input int done_dly, input bit clr_prio);
    if (idx < 0) begin
      tick();
      checkOutput("spurious_clear", 32'(interrupt_clear), 32'd1);
      exp_spurious = (exp_spurious < 255) ? exp_spurious + 1 : 255;
      return;
    end
    tick();
    checkOutput("req_rise", 32'(irq_req), 32'd1);
    checkOutput("irq_id", 32'(irq_id), 32'(idx));
    for (int k = 0; k < ack_dly; k++) begin
      irq_done = 1'($urandom_range(0, 1));
      tick();
      checkOutput("req_hold", 32'(irq_req), 32'd1);
      checkOutput("id_hold", 32'(irq_id), 32'(idx));
    end
    irq_done = 1'b0;
    irq_ack  = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("req_drop", 32'(irq_req), 32'd0);
    if (done_dly >= 0) begin
      for (int k = 0; k < done_dly; k++) begin
        irq_ack = 1'($urandom_range(0, 1));
        tick();
      end
      irq_ack = 1'b0;
      checkOutput("no_early_clear", 32'(interrupt_clear), 32'd0);
      irq_done = 1'b1;
      tick();
      irq_done = 1'b0;
      checkOutput("done_clear", 32'(interrupt_clear), 32'd1);
      exp_serviced = (exp_serviced < SERVICED_MAX) ? exp_serviced + 1 : SERVICED_MAX;
    end else begin
      for (int k = 0; k < TIMEOUT_CYCLES - 1; k++) begin
        irq_ack = 1'($urandom_range(0, 1));
        tick();
      end
      irq_ack = 1'b0;
      checkOutput("timeout_not_yet", 32'(interrupt_clear), 32'd0);
      timeout_clr = clr_prio;
      tick();
      timeout_clr = 1'b0;
      checkOutput("timeout_clear", 32'(interrupt_clear), 32'd1);
      exp_flag = !clr_prio;
    end
  endtask

  task automatic finishTxn(input int clear_before, input int req_before, input int n_clears, input int n_reqs);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    checkOutput("holdoff_len", 32'(n), 32'(HOLDOFF_CYCLES + 1));
    checkOutput("clear_pulses", 32'(clear_count - clear_before), 32'(n_clears));
    checkOutput("req_pulses", 32'(req_rises - req_before), 32'(n_reqs));
    checkOutput("serviced_cnt", 32'(serviced_cnt), 32'(exp_serviced));
    checkOutput("spurious_cnt", 32'(spurious_cnt), 32'(exp_spurious));
    checkOutput("timeout_flag", 32'(timeout_flag), 32'(exp_flag));
  endtask

  task automatic applyStimulus(input logic [31:0] svc, input int plen, input int ack_dly,
                               input int done_dly, input bit clr_prio);
    int cb  = clear_count;
    int rb  = req_rises;
    int idx = ref_index(svc);
    int n   = 0;
    interrupt_serviceInterrupt = svc;
    proc_interrupt = 1'b1;
    pulse_left     = plen;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    checkOutput("capture_latency", 32'(n), 32'd2);
    serviceTxn(idx, ack_dly, done_dly, clr_prio);
    finishTxn(cb, rb, 1, (idx < 0) ? 0 : 1);
    while (pulse_left > 0) tick();
    tick();
  endtask

  task automatic resetCheck(input string tag);
    rst_n = 1'b0;
    #1;
    exp_serviced = 0;
    exp_spurious = 0;
    exp_flag     = 1'b0;
    checkOutput({tag, "_req"}, 32'(irq_req), 32'd0);
    checkOutput({tag, "_clear"}, 32'(interrupt_clear), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_serviced"}, 32'(serviced_cnt), 32'd0);
    checkOutput({tag, "_spurious"}, 32'(spurious_cnt), 32'd0);
    checkOutput({tag, "_flag"}, 32'(timeout_flag), 32'd0);
    checkOutput({tag, "_id"}, 32'(irq_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] one = 32'h1;
    logic [31:0] svc;
    int cb, rb, n, a, b, done;

    #2;
    resetCheck("reset");
    dispatch_en = 1'b1;

    // single dispatch, then spurious zero and multi-hot captures
    applyStimulus(32'h0000_0010, 7, 2, 5, 1'b0);
    applyStimulus(32'h0000_0000, 3, 0, 0, 1'b0);
    applyStimulus(32'h0000_0005, 3, 0, 0, 1'b0);

    // minimum latency, then timeout, explicit clear, clear-vs-set priority, done at the limit
    applyStimulus(32'h0000_0001, 1, 0, 0, 1'b0);
    applyStimulus(32'h0000_0200, 2, 1, -1, 1'b0);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    exp_flag = 1'b0;
    checkOutput("timeout_clr", 32'(timeout_flag), 32'd0);
    applyStimulus(32'h0000_0400, 2, 0, -1, 1'b1);
    applyStimulus(32'h0001_0000, 2, 0, TIMEOUT_CYCLES - 1, 1'b0);

    // handshake inputs while idle are ignored
    cb = clear_count;
    rb = req_rises;
    irq_ack  = 1'b1;
    irq_done = 1'b1;
    repeat (3) tick();
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    checkOutput("idle_ignore_busy", 32'(busy), 32'd0);
    checkOutput("idle_ignore_cnt", 32'(serviced_cnt), 32'(exp_serviced));
    checkOutput("idle_ignore_req", 32'(req_rises - rb), 32'd0);

    // gated dispatch: rise held pending until enable
    cb = clear_count;
    rb = req_rises;
    dispatch_en = 1'b0;
    interrupt_serviceInterrupt = 32'h8000_0000;
    proc_interrupt = 1'b1;
    pulse_left = 7;
    repeat (20) tick();
    checkOutput("gated_idle", 32'(busy), 32'd0);
    dispatch_en = 1'b1;
    tick();
    checkOutput("gated_capture", 32'(busy), 32'd1);
    serviceTxn(31, 1, 3, 1'b0);
    finishTxn(cb, rb, 1, 1);
    tick();

    // back-to-back: second rise during HOLDOFF
    cb = clear_count;
    rb = req_rises;
    interrupt_serviceInterrupt = 32'h0000_0100;
    proc_interrupt = 1'b1;
    pulse_left = 1;
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    checkOutput("b2b_first_capture", 32'(n), 32'd2);
    serviceTxn(8, 0, 0, 1'b0);
    tick();
    interrupt_serviceInterrupt = 32'h0040_0000;
    proc_interrupt = 1'b1;
    pulse_left = 2;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    checkOutput("b2b_holdoff", 32'(n), 32'(HOLDOFF_CYCLES));
    tick();
    checkOutput("b2b_capture", 32'(busy), 32'd1);
    serviceTxn(22, 1, 1, 1'b0);
    finishTxn(cb, rb, 2, 2);
    tick();

    // randomized mix of one-hot, zero and multi-hot words
    for (int r = 0; r < 40; r++) begin
      a = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       svc = '0;
        1: begin
          b   = (a + 1 + $urandom_range(0, 30)) % 32;
          svc = (one << a) | (one << b);
        end
        default: svc = one << a;
      endcase
      done = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, TIMEOUT_CYCLES - 1);
      applyStimulus(svc, $urandom_range(1, 7), $urandom_range(0, 3), done, $urandom_range(0, 3) == 0);
    end

    // drive both counters into saturation
    for (int k = 0; k < SERVICED_MAX + 2; k++)
      applyStimulus(one << (k % 32), 1, 0, 0, 1'b0);
    for (int k = 0; k < 258; k++)
      applyStimulus(32'h0000_0000, 1, 0, 0, 1'b0);
    checkOutput("serviced_sat", 32'(serviced_cnt), 32'(SERVICED_MAX));
    checkOutput("spurious_sat", 32'(spurious_cnt), 32'd255);

    // reset while a request is outstanding
    interrupt_serviceInterrupt = 32'h0000_0004;
    proc_interrupt = 1'b1;
    pulse_left = 1;
    repeat (3) tick();
    checkOutput("pre_reset_req", 32'(irq_req), 32'd1);
    resetCheck("reset_dispatch");
    tick();

    // reset mid-SERVICE: nothing follows after release
    interrupt_serviceInterrupt = 32'h0000_0004;
    proc_interrupt = 1'b1;
    pulse_left = 1;
    repeat (3) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    cb = clear_count;
    resetCheck("reset_service");
    repeat (20) tick();
    checkOutput("post_reset_clear", 32'(clear_count - cb), 32'd0);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
